pcie_tx_framer: RTL
===================

Name: pcie_tx_framer

Overview:
- FPGA-side producer for the tx fifobus that the PCIe/Xillybus link drains toward the host on /dev/xillybus_read_32.
- Accepts a start command (opcode, length) and a valid/ready stream of 32-bit result words.
- Writes one framed packet into the tx FIFO: a header word, the payload, then a checksum trailer word.
- Stalls on FIFO full, so the host sees complete, self-describing frames.

Parameters:
- WORD_W, 32, FIFO word width in bits; header/trailer layout requires 32.
- LEN_W, 16, width of payload length field in words.
- SEQ_W, 8, width of wrapping frame sequence counter.

Ports:
- clk  in  1  bus clock, the same clock the PCIe wrapper drives out.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- opcode  in  8  frame type, latched on accepted start.
- len  in  LEN_W  payload word count, latched on accepted start; 0 is legal.
- busy  out  1  high from accepted start until the trailer is written.
- din  in  WORD_W  payload word.
- din_valid  in  1  payload word present.
- din_ready  out  1  framer can take din this cycle.
- tx_d  out  WORD_W  word to tx FIFO (tx.d.value).
- tx_wrreq  out  1  write strobe to tx FIFO.
- tx_full  in  1  tx FIFO full.
- done  out  1  one-cycle pulse on the cycle the trailer is written.
- frames_sent  out  SEQ_W  current sequence number, equal to the count of completed frames mod 2^SEQ_W.

Behaviour:
- FSM states: IDLE, HDR, PAY, TRL.
- Reset (async, any state): state=IDLE, busy=0, done=0, tx_wrreq=0, din_ready=0, frames_sent=0, checksum=0, word counter=0.
  - A partial frame already in the FIFO is left there; the host resyncs on the header.
- IDLE:
  - start=1 latches opcode and len, clears checksum, moves to HDR, sets busy=1 next cycle.
  - start in any other state is ignored; no queueing.
- HDR:
  - Header word = {frames_sent, opcode, len}, in bits [31:24], [23:16], [15:0].
  - When !tx_full: tx_wrreq=1 and checksum=header.
  - Next state is PAY if len!=0, else TRL.
- PAY:
  - din_ready = !tx_full (combinational).
  - Transfer occurs when din_valid && din_ready. On transfer, same cycle: tx_d=din, tx_wrreq=1, checksum += din (mod 2^32), counter++.
  - After the len-th transfer, move to TRL.
  - No transfer means no write and no counter change.
- TRL:
  - When !tx_full: tx_d = checksum (32-bit wrap sum of header and all payload words), tx_wrreq=1, done=1.
  - frames_sent++ (wraps 0xFF to 0x00), busy=0 next cycle, state=IDLE.
- tx_wrreq is asserted only in a cycle where tx_full=0. No write may ever occur while full.
- tx_d and tx_wrreq are combinational from state/din/checksum, with zero added latency.
  - Minimum frame time is len+2 cycles with no stalls.
- din_ready=0 outside PAY, so din is never consumed between frames.
- start is accepted no earlier than the cycle after done, giving back-to-back frames with one IDLE cycle.
- Counter width is LEN_W; len=2^LEN_W-1 is legal and must not wrap early.

Decomposition:
- Shared package (globals) holds:
  - tx_hdr_t packed struct {seq[7:0], opcode[7:0], len[15:0]}.
  - Opcode constants for result/status frames.
  - Framer state enum type.
- Sub-module pcie_tx_cksum holds the 32-bit accumulator with clear/load/add controls and async reset.
- The FSM, counter and muxing stay in pcie_tx_framer.

Test Plan:
- opcode=0x01, len=3, din 0x10,0x20,0x30 streamed, tx_full=0:
  - FIFO gets 0x00010003, 0x10, 0x20, 0x30, 0x00010063.
  - done pulses on cycle 5 after start; frames_sent=1.
- len=0, opcode=0x7F:
  - FIFO gets 0x007F0000, then trailer 0x007F0000; no din consumed.
- Same frame as the first scenario with tx_full held high 4 cycles during PAY:
  - No tx_wrreq and din_ready=0 during the stall.
  - Output words are identical to the first scenario.
- din_valid gapped (1,0,0,1,1):
  - Only 3 writes in PAY.
  - start pulsed mid-frame is ignored and busy stays high.
- reset asserted mid-PAY after 2 of 5 words:
  - busy, tx_wrreq and din_ready drop to 0 immediately; frames_sent=0.
  - The next frame's header has seq=0.
- 257 back-to-back len=1 frames:
  - frames_sent wraps to 0x01.
  - The 257th header has seq=0x00.
  - Every trailer equals header+payload mod 2^32.

Source files
------------

// File: rtl/pcie_tx_framer_pkg.sv
// Shared types and constants for the PCIe tx framer.
package pcie_tx_framer_pkg;

  // Frame type codes carried in the header opcode field
  localparam logic [7:0] OP_RESULT = 8'h01;
  localparam logic [7:0] OP_STATUS = 8'h7F;

  // Header word layout: [31:24] seq, [23:16] opcode, [15:0] len
  typedef struct packed {
    logic [7:0]  seq;
    logic [7:0]  opcode;
    logic [15:0] len;
  } tx_hdr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2,
    S_TRL  = 2'd3
  } framer_state_t;

endpackage

// File: rtl/pcie_tx_cksum.sv
// Running 32-bit wrap-around checksum accumulator.
module pcie_tx_cksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  // Accumulator: clear has priority over load, load over add
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (load) begin
      sum <= din;
    end else if (add) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/pcie_tx_framer.sv
// Frames a result stream into header / payload / checksum trailer for the tx FIFO.
module pcie_tx_framer
  import pcie_tx_framer_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16,
  parameter int SEQ_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        opcode,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [WORD_W-1:0] tx_d,
  output logic              tx_wrreq,
  input  logic              tx_full,
  output logic              done,
  output logic [SEQ_W-1:0]  frames_sent
);

  framer_state_t     state, next_state;
  logic [7:0]        opcode_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  tx_hdr_t           hdr;

  logic              ck_clr, ck_load, ck_add;
  logic [WORD_W-1:0] ck_in, ck_sum;
  logic              accept, xfer, trl_wr;

  assign hdr  = {frames_sent, opcode_q, len_q};
  assign busy = (state != S_IDLE);

  pcie_tx_cksum #(.W(WORD_W)) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clr   (ck_clr),
    .load  (ck_load),
    .add   (ck_add),
    .din   (ck_in),
    .sum   (ck_sum)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next state, FIFO write mux and checksum controls
  always_comb begin
    next_state = state;
    tx_d       = '0;
    tx_wrreq   = 1'b0;
    din_ready  = 1'b0;
    done       = 1'b0;
    ck_clr     = 1'b0;
    ck_load    = 1'b0;
    ck_add     = 1'b0;
    ck_in      = '0;
    accept     = 1'b0;
    xfer       = 1'b0;
    trl_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          ck_clr     = 1'b1;
          next_state = S_HDR;
        end
      end
      S_HDR: begin
        tx_d  = hdr;
        ck_in = hdr;
        if (!tx_full) begin
          tx_wrreq   = 1'b1;
          ck_load    = 1'b1;
          next_state = (len_q != '0) ? S_PAY : S_TRL;
        end
      end
      S_PAY: begin
        din_ready = !tx_full;
        tx_d      = din;
        ck_in     = din;
        if (din_valid && !tx_full) begin
          xfer     = 1'b1;
          tx_wrreq = 1'b1;
          ck_add   = 1'b1;
          // Compare against len-1 so len = all-ones never needs cnt to wrap
          if (cnt == len_q - LEN_W'(1)) next_state = S_TRL;
        end
      end
      S_TRL: begin
        tx_d = ck_sum;
        if (!tx_full) begin
          trl_wr     = 1'b1;
          tx_wrreq   = 1'b1;
          done       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Command latch, payload counter and frame sequence number
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q    <= '0;
      len_q       <= '0;
      cnt         <= '0;
      frames_sent <= '0;
    end else begin
      if (accept) begin
        opcode_q <= opcode;
        len_q    <= len;
        cnt      <= '0;
      end
      if (xfer)   cnt         <= cnt + LEN_W'(1);
      if (trl_wr) frames_sent <= frames_sent + SEQ_W'(1);
    end
  end

endmodule
